// File: rtl/lcd_pkg.sv
// Shared LCD types and constants: line width, blank line, source indices,
// arbiter state encoding and small request-vector helpers.
package lcd_pkg;
   localparam int LCD_LINE_W = 128;
   localparam int LCD_NSRC   = 3;
   localparam logic [LCD_LINE_W-1:0] LCD_SPACE_LINE = {16{8'h20}};

   localparam logic [1:0] SRC_CLK = 2'd0;
   localparam logic [1:0] SRC_SET = 2'd1;
   localparam logic [1:0] SRC_ALM = 2'd2;

   typedef enum logic [1:0] {IDLE, HOLD, OWN} arb_state_t;

   typedef struct packed {
      logic [LCD_LINE_W-1:0] line_b;
      logic [LCD_LINE_W-1:0] line_a;
   } lcd_lines_t;

   // Highest set index; source 0 is the fallback when nothing is set.
   function automatic logic [1:0] top_req(input logic [LCD_NSRC-1:0] v);
      top_req = SRC_CLK;
      for (int j = 0; j < LCD_NSRC; j++)
         if (v[j]) top_req = 2'(j);
   endfunction

   function automatic logic [LCD_NSRC-1:0] onehot(input logic [1:0] idx);
      onehot = 3'b001 << idx;
   endfunction

   // Sources strictly above idx in priority.
   function automatic logic [LCD_NSRC-1:0] above_mask(input logic [1:0] idx);
      above_mask = 3'b110 << idx;
   endfunction
endpackage

// File: rtl/ms_tick_gen.sv
// Free-running 1 ms strobe: one-cycle pulse every MFREQ_KHZ mclk cycles.
module ms_tick_gen #(
   parameter int MFREQ_KHZ = 1
) (
   input  logic mclk,
   input  logic rst,
   output logic tick
);
   localparam int CW = (MFREQ_KHZ > 1) ? $clog2(MFREQ_KHZ) : 1;

   logic [CW-1:0] tick_cnt;

   assign tick = (tick_cnt == CW'(MFREQ_KHZ - 1));

   always_ff @(posedge mclk or negedge rst) begin
      if (!rst)      tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + 1'b1;
   end
endmodule

// File: rtl/lcd_line_arbiter.sv
// Grants the two LCD lines to one of three sources with a minimum hold time.
// Optional ownership timeout with per-source lockout: define LCD_ARB_TIMEOUT_EN.
module lcd_line_arbiter
   import lcd_pkg::*;
#(
   parameter int MFREQ_KHZ  = 1,
   parameter int HOLD_MS    = 500,
   parameter int TIMEOUT_MS = 10000
) (
   input  logic                        mclk,
   input  logic                        rst,
   input  logic [LCD_NSRC-1:0]         req,
   input  logic [LCD_NSRC-1:0]         wr,
   input  logic [2*LCD_NSRC*LCD_LINE_W-1:0] lines_in,
   output logic [LCD_NSRC-1:0]         gnt,
   output logic [LCD_LINE_W-1:0]       LineA,
   output logic [LCD_LINE_W-1:0]       LineB,
   output logic                        upd
);
   localparam logic [15:0] HOLD_W = 16'(HOLD_MS);

   logic                tick;
   logic [1:0]          owner, nxt_owner, pre, src;
   arb_state_t          state, nxt_state;
   logic [15:0]         hold_cnt, nxt_hold;
   logic [LCD_NSRC-1:0] elig;
   logic                timeout, revoke, chg, load;
   lcd_lines_t          lines_q;
   lcd_lines_t          src_lines [LCD_NSRC];

   ms_tick_gen #(.MFREQ_KHZ(MFREQ_KHZ)) u_tick (
      .mclk (mclk),
      .rst  (rst),
      .tick (tick)
   );

   for (genvar k = 0; k < LCD_NSRC; k++) begin : g_src
      assign src_lines[k] = lines_in[k*2*LCD_LINE_W +: 2*LCD_LINE_W];
   end

`ifdef LCD_ARB_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_MS);

   logic [15:0] own_cnt;
   logic [2:1]  lock;

   assign timeout = (owner != SRC_CLK) && (own_cnt >= TIMEOUT_W);
   assign elig    = req & {~lock, 1'b0};

   always_ff @(posedge mclk or negedge rst) begin
      if (!rst) begin
         own_cnt <= '0;
         lock    <= '0;
      end else begin
         if (chg)                           own_cnt <= '0;
         else if (tick && own_cnt != 16'hFFFF) own_cnt <= own_cnt + 16'd1;
         // A revoked source stays out until it has been seen idle once.
         for (int k = 1; k < LCD_NSRC; k++) begin
            if (revoke && owner == 2'(k)) lock[k] <= 1'b1;
            else if (!req[k])             lock[k] <= 1'b0;
         end
      end
   end
`else
   assign timeout = 1'b0;
   assign elig    = req & 3'b110;
`endif

   always_comb begin
      nxt_owner = owner;
      revoke    = 1'b0;
      pre       = top_req(elig & above_mask(owner));
      if (pre != SRC_CLK) begin
         nxt_owner = pre;
      end else if ((state == OWN && !req[owner]) || timeout) begin
         nxt_owner = top_req(elig & ~onehot(owner));
         revoke    = timeout;
      end
   end

   assign chg  = (nxt_owner != owner);
   assign load = chg || wr[owner];
   assign src  = chg ? nxt_owner : owner;

   always_comb begin
      nxt_hold = hold_cnt;
      if (chg)                                nxt_hold = '0;
      else if (tick && hold_cnt != 16'hFFFF)  nxt_hold = hold_cnt + 16'd1;
   end

   // State tracks "owner > 0 and hold time met" for the cycle after the edge.
   always_comb begin
      if (nxt_owner == SRC_CLK)     nxt_state = IDLE;
      else if (nxt_hold >= HOLD_W)  nxt_state = OWN;
      else                          nxt_state = HOLD;
   end

   always_ff @(posedge mclk or negedge rst) begin
      if (!rst) begin
         owner    <= SRC_CLK;
         gnt      <= 3'b001;
         state    <= IDLE;
         hold_cnt <= '0;
         lines_q  <= '{line_b: LCD_SPACE_LINE, line_a: LCD_SPACE_LINE};
         upd      <= 1'b0;
      end else begin
         owner    <= nxt_owner;
         gnt      <= onehot(nxt_owner);
         state    <= nxt_state;
         hold_cnt <= nxt_hold;
         upd      <= load;
         if (load) lines_q <= src_lines[src];
      end
   end

   assign LineA = lines_q.line_a;
   assign LineB = lines_q.line_b;
endmodule

// File: tb/tb_lcd_line_arbiter.sv
// Directed bench for lcd_line_arbiter (MFREQ_KHZ=4, HOLD_MS=3, TIMEOUT_MS=5).
module tb_lcd_line_arbiter;
   localparam logic [127:0] SPC = {16{8'h20}};
   localparam logic [127:0] S0A = "MON 12:00:00 AM ";
   localparam logic [127:0] S0B = "CLOCK MODE      ";
   localparam logic [127:0] S1A = "SET HOUR: 07    ";
   localparam logic [127:0] S1B = "PRESS TO ADVANCE";
   localparam logic [127:0] S2A = "ALARM!  ALARM!  ";
   localparam logic [127:0] S2B = "PRESS TO SNOOZE ";
   localparam logic [127:0] S2X = "WAKE UP NOW     ";

   logic         mclk = 1'b0;
   logic         rst;
   logic [2:0]   req, wr;
   logic [767:0] lines_in;
   logic [2:0]   gnt;
   logic [127:0] LineA, LineB;
   logic         upd;

   int checks = 0;
   int errors = 0;
   int n;

   lcd_line_arbiter #(.MFREQ_KHZ(4), .HOLD_MS(3), .TIMEOUT_MS(5)) dut (
      .mclk(mclk), .rst(rst), .req(req), .wr(wr), .lines_in(lines_in),
      .gnt(gnt), .LineA(LineA), .LineB(LineB), .upd(upd)
   );

   always #5 mclk = ~mclk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   // Step until gnt equals g or the bound runs out; cycles stepped in cnt.
   task automatic wait_gnt(input logic [2:0] g, input int bound, output int cnt);
      cnt = 0;
      for (int i = 0; i < bound; i++) begin
         step();
         cnt++;
         if (gnt === g) break;
      end
   endtask

   initial begin
      rst = 1'b0; req = '0; wr = '0;
      lines_in = {S2B, S2A, S1B, S1A, S0B, S0A};
      #12;
      chk("rst_gnt", 128'(gnt), 128'(3'b001));
      chk("rst_linea", LineA, SPC);
      chk("rst_lineb", LineB, SPC);
      chk("rst_upd", 128'(upd), 128'(1'b0));

      @(negedge mclk); rst = 1'b1;
      step(); step();
      chk("idle_upd", 128'(upd), 128'(1'b0));

      // owner-0 write
      wr = 3'b001; step(); wr = '0;
      chk("wr0_linea", LineA, S0A);
      chk("wr0_lineb", LineB, S0B);
      chk("wr0_upd", 128'(upd), 128'(1'b1));
      step();
      chk("wr0_upd_end", 128'(upd), 128'(1'b0));

      // non-owner write ignored
      wr = 3'b010; step(); wr = '0;
      chk("nonown_upd", 128'(upd), 128'(1'b0));
      chk("nonown_linea", LineA, S0A);
      chk("nonown_gnt", 128'(gnt), 128'(3'b001));

      // hold: req[1] for 2 cycles, ownership held for 3 ticks
      req = 3'b010; step();
      chk("hold_gnt", 128'(gnt), 128'(3'b010));
      chk("hold_linea", LineA, S1A);
      chk("hold_upd", 128'(upd), 128'(1'b1));
      step();
      req = '0;
      wait_gnt(3'b001, 30, n);
      chk("hold_len_ok", 128'(n + 1 >= 10 && n + 1 <= 13), 128'(1'b1));
      chk("rel_gnt", 128'(gnt), 128'(3'b001));
      chk("rel_linea", LineA, S0A);
      chk("rel_upd", 128'(upd), 128'(1'b1));

      // preemption in HOLD with a simultaneous write from the old owner
      req = 3'b010; step();
      chk("pre_own1", 128'(gnt), 128'(3'b010));
      req = 3'b110; wr = 3'b010; step(); wr = '0;
      chk("pre_gnt", 128'(gnt), 128'(3'b100));
      chk("pre_linea", LineA, S2A);
      chk("pre_lineb", LineB, S2B);
      chk("pre_upd", 128'(upd), 128'(1'b1));
      req = 3'b100;
      for (int i = 0; i < 20; i++) step();
      chk("alm_keep", 128'(gnt), 128'(3'b100));

      // owner write, held two cycles -> two reloads
      lines_in[512 +: 128] = S2X;
      wr = 3'b100; step();
      chk("own_wr_linea", LineA, S2X);
      chk("own_wr_upd1", 128'(upd), 128'(1'b1));
      step(); wr = '0;
      chk("own_wr_upd2", 128'(upd), 128'(1'b1));
      step();
      chk("own_wr_upd3", 128'(upd), 128'(1'b0));

      // release from OWN is immediate
      req = '0; step();
      chk("alm_rel_gnt", 128'(gnt), 128'(3'b001));
      chk("alm_rel_linea", LineA, S0A);

      // continuous req[1]
      req = 3'b010; step();
      chk("to_own", 128'(gnt), 128'(3'b010));
`ifdef LCD_ARB_TIMEOUT_EN
      wait_gnt(3'b001, 40, n);
      chk("to_len_ok", 128'(n + 1 >= 18 && n + 1 <= 21), 128'(1'b1));
      chk("to_gnt", 128'(gnt), 128'(3'b001));
      for (int i = 0; i < 10; i++) step();
      chk("to_locked", 128'(gnt), 128'(3'b001));
      req = '0; step();
      req = 3'b010; step();
      chk("to_regrant", 128'(gnt), 128'(3'b010));
      req = '0;
      wait_gnt(3'b001, 30, n);
      chk("to_rel", 128'(gnt), 128'(3'b001));
`else
      for (int i = 0; i < 40; i++) step();
      chk("no_to_keep", 128'(gnt), 128'(3'b010));
      req = '0; step();
      chk("no_to_rel", 128'(gnt), 128'(3'b001));
`endif

      // asynchronous reset during HOLD
      req = 3'b010; step();
      chk("ar_own", 128'(gnt), 128'(3'b010));
      chk("ar_linea", LineA, S1A);
      #2 rst = 1'b0;
      #1;
      chk("ar_gnt", 128'(gnt), 128'(3'b001));
      chk("ar_linea_rst", LineA, SPC);
      chk("ar_lineb_rst", LineB, SPC);
      chk("ar_upd", 128'(upd), 128'(1'b0));
      req = '0;
      @(negedge mclk); rst = 1'b1;
      step();
      req = 3'b010; step();
      chk("ar_regrant", 128'(gnt), 128'(3'b010));
      chk("ar_regrant_linea", LineA, S1A);
      chk("ar_regrant_upd", 128'(upd), 128'(1'b1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/lcd_line_arbiter.md
# lcd_line_arbiter

Arbitrates ownership of the two 16-character LCD lines among three content sources: clock display, set-mode editor and alarm screen. Each source drives its own lines. The arbiter grants exactly one owner at a time and enforces a minimum on-screen hold time. It registers the owner's text onto `LineA`/`LineB`, which feed `lcd_controller`. It sits between the clock/alarm logic and `lcd_controller`, and replaces direct line assignment in `lcd_display_controller`.

## Interface
Parameters:
- `MFREQ_KHZ`, default 1: number of `mclk` cycles per 1 ms tick; must be ≥1.
- `HOLD_MS`, default 500: minimum ms a non-default owner keeps the display; 16-bit.
- `TIMEOUT_MS`, default 10000: maximum ownership in ms for requesters 1–2; 16-bit; used only with the macro.

Ports:
- `mclk` in 1: the only clock.
- `rst` in 1: asynchronous, active-low reset.
- `req` in 3: per-source request; index 2 = alarm (highest priority), 1 = set-mode, 0 = clock (default owner).
- `wr` in 3: per-source content-valid strobe, one cycle.
- `lines_in` in 768: packed source text; source k occupies `[256k+:256]`, with `{LineB, LineA}` order inside each slice.
- `gnt` out 3: one-hot current owner.
- `LineA` out 128: registered line 1 text.
- `LineB` out 128: registered line 2 text.
- `upd` out 1: one-cycle pulse whenever `LineA`/`LineB` load.

## Operation
- Reset values: `gnt`=3'b001, `LineA`=`LineB`=16×8'h20, `upd`=0, state IDLE, all counters 0.
- ms tick: `tick_cnt` counts 0..MFREQ_KHZ-1. `tick` pulses on the cycle `tick_cnt`==MFREQ_KHZ-1, then `tick_cnt` wraps to 0.
- `hold_cnt`, 16 bits: cleared on every owner change, incremented on `tick`, saturates at 16'hFFFF. `hold_done` is asserted when `hold_cnt`≥HOLD_MS.
- States:
  - IDLE: owner is 0.
  - HOLD: owner is k>0 and `hold_done`=0.
  - OWN: owner is k>0 and `hold_done`=1.
- Transitions (evaluated every cycle, in priority order):
  1. A pending `req[j]` with j > owner preempts immediately, in any state. The new owner is the highest such j, and the next state is HOLD.
  2. In OWN, if the owner's `req` is low, the new owner is the highest pending request among 1–2. If none is pending, the owner returns to 0 and the state to IDLE.
  3. In HOLD, the owner dropping `req` does not release ownership. Release is deferred until `hold_done`.
- Load: on an owner change, `{LineB,LineA}` ← new owner's slice. Otherwise, `wr[owner]`=1 loads the owner's slice. `wr` from a non-owner is ignored.
- `upd`=1 on exactly the cycles where a load occurs.
- `req[0]` is ignored for arbitration; source 0 owns the display whenever no other source does.

## Timing
- Latency: `req` sampled at edge n gives `gnt`, lines and `upd` updated at edge n+1.
- Simultaneous events:
  - Preemption and `wr[old owner]` in the same cycle: the preemption wins and the new owner's slice loads.
  - Preemption and hold expiry in the same cycle: rule 1 applies.
- `wr` pulses longer than one cycle reload every cycle; each reload produces an `upd` pulse.
- HOLD_MS=0: `hold_done` is true immediately after an owner change, so release may occur on the next cycle.
- A `rst` assertion mid-HOLD immediately forces the reset values, independent of `mclk`.
- Deassertion of `rst` is synchronised externally.

## Configuration
- `LCD_ARB_TIMEOUT_EN`:
  - Defined: a 16-bit `own_cnt` clears on owner change and counts ticks. When `own_cnt`≥TIMEOUT_MS and owner k>0, ownership is revoked as in rule 2, regardless of `req[k]`. Source k is then locked out until its `req` is sampled low. Lockouts clear on reset.
  - Undefined: no `own_cnt`, no lockout; a source keeps ownership for as long as it requests.

## Structure
- `lcd_pkg`:
  - `LCD_SPACE_LINE` (16×8'h20).
  - Source index constants `SRC_CLK`/`SRC_SET`/`SRC_ALM`.
  - Arbiter state enum IDLE/HOLD/OWN.
  - `LCD_LINE_W`=128.
- Sub-module `ms_tick_gen` (parameter MFREQ_KHZ; ports `mclk`, `rst`, `tick`). It is reused by other timing blocks.

## Test plan
- Reset, MFREQ_KHZ=4: with `rst` low → `gnt`=001, `LineA`=`LineB`=all 8'h20, `upd`=0. After `rst` high, `wr[0]` with slice 0 = "MON…" → `LineA`="MON…" one edge later, `upd` pulse of 1 cycle.
- Preemption: owner 1 in HOLD, `req[2]` rises → `gnt`=100 and lines = slice 2 at the next edge. A simultaneous `wr[1]` is ignored.
- Hold, HOLD_MS=3, MFREQ_KHZ=4: `req[1]` held for 2 cycles then dropped → `gnt`=010 persists until the 3rd tick (≈12 cycles), then 001 with lines = slice 0.
- Non-owner write: owner 0, `wr[1]` pulse → no `upd`, lines unchanged.
- Timeout (macro on, TIMEOUT_MS=5): `req[1]` held continuously → `gnt` returns to 001 after 5 ticks and stays there until `req[1]` drops and rises again.
- Mid-operation reset: `rst` asserted during HOLD, asynchronously between edges → outputs reach reset values without an `mclk` edge. After release, a new `req[1]` takes ownership normally.
